ring_relay_buffer: RTL and testbench



---
 rtl/ring_relay_buffer_pkg.sv | 28 ++
 rtl/ring_relay_buffer_if.sv | 33 +++
 rtl/ring_relay_buffer_node.sv | 119 +++++++++++
 rtl/ring_relay_buffer.sv | 54 +++++
 tb/tb_ring_relay_buffer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_relay_buffer_pkg.sv
// Sizing helpers and shared types for the ring relay buffer and its nodes.
package ring_relay_pkg;

   typedef enum logic [1:0] {
      HD_EMPTY,
      HD_DELIVER,
      HD_FORWARD,
      HD_STALL
   } head_act_e;

   function automatic int dest_w(input int nodes);
      return (nodes <= 2) ? 1 : $clog2(nodes);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // A stored entry is {dest, data}.
   function automatic int entry_w(input int nodes, input int width);
      return dest_w(nodes) + width;
   endfunction

endpackage

// File: rtl/ring_relay_buffer_if.sv
// Bundle between the switch/key injection side, the relay ring and the per-node display side.
interface ring_relay_buffer_if #(
   parameter int NODES = 2,
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
);
   import ring_relay_pkg::*;

   localparam int DW = dest_w(NODES);
   localparam int CW = cnt_w(DEPTH);

   logic [NODES-1:0]       inj_valid;
   logic [NODES*WIDTH-1:0] inj_data;
   logic [NODES*DW-1:0]    inj_dest;
   logic [NODES-1:0]       inj_ready;
   logic [NODES-1:0]       out_valid;
   logic [NODES*WIDTH-1:0] out_data;
   logic [NODES-1:0]       out_ready;
   logic [NODES*CW-1:0]    occupancy;
   logic [NODES-1:0]       stalled;
   logic [NODES-1:0]       drop_pulse;

   modport master (
      output inj_valid, inj_data, inj_dest, out_ready,
      input  inj_ready, out_valid, out_data, occupancy, stalled, drop_pulse
   );

   modport slave (
      input  inj_valid, inj_data, inj_dest, out_ready,
      output inj_ready, out_valid, out_data, occupancy, stalled, drop_pulse
   );

endinterface

// File: rtl/ring_relay_buffer_node.sv
// One ring stop: DEPTH-entry FIFO, head decode, ring-over-inject write arbitration and status.
module ring_node
   import ring_relay_pkg::*;
#(
   parameter int NODES = 2,
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,
   parameter int ID    = 0,
   localparam int DW   = dest_w(NODES),
   localparam int CW   = cnt_w(DEPTH),
   localparam int EW   = entry_w(NODES, WIDTH),
   localparam int PW   = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inj_valid_i,
   input  logic [WIDTH-1:0] inj_data_i,
   input  logic [DW-1:0]    inj_dest_i,
   output logic             inj_ready_o,
   input  logic             ring_valid_i,
   input  logic [EW-1:0]    ring_entry_i,
   input  logic [CW-1:0]    ds_count_i,
   output logic             fwd_valid_o,
   output logic [EW-1:0]    fwd_entry_o,
   output logic [CW-1:0]    count_o,
   output logic             out_valid_o,
   output logic [WIDTH-1:0] out_data_o,
   input  logic             out_ready_i,
   output logic             stalled_o,
   output logic             drop_pulse_o
);

   localparam logic [DW:0]   NODES_X  = (DW + 1)'(NODES);
   localparam logic [DW-1:0] MY_ID    = DW'(ID);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [CW-1:0] INJ_MAX  = CW'(DEPTH - 2);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [EW-1:0] mem_q [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          drop_q, drop_d;

   logic [EW-1:0] head;
   logic [DW-1:0] head_dest;
   logic          head_local;
   logic          fwd;
   head_act_e     head_act;
   logic          pop;
   logic          inj_ready;
   logic          inj_take;
   logic          inj_in_range;
   logic          push;
   logic [EW-1:0] push_entry;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      head       = mem_q[rd_ptr_q];
      head_dest  = head[EW-1 -: DW];
      head_local = (count_q != '0) && (head_dest == MY_ID);
      // Forwarding looks only at the registered downstream count, never its pop.
      fwd        = (count_q != '0) && (head_dest != MY_ID) && (ds_count_i < FULL);

      if (count_q == '0)   head_act = HD_EMPTY;
      else if (head_local) head_act = out_ready_i ? HD_DELIVER : HD_STALL;
      else if (fwd)        head_act = HD_FORWARD;
      else                 head_act = HD_STALL;

      pop = (head_act == HD_DELIVER) || (head_act == HD_FORWARD);

      // Injection keeps one slot in reserve so ring traffic can always advance.
      inj_ready    = (count_q <= INJ_MAX) && !ring_valid_i;
      inj_take     = inj_valid_i && inj_ready;
      inj_in_range = {1'b0, inj_dest_i} < NODES_X;
      push         = ring_valid_i || (inj_take && inj_in_range);
      push_entry   = ring_valid_i ? ring_entry_i : {inj_dest_i, inj_data_i};

      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      drop_d = inj_take && !inj_in_range;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   assign inj_ready_o  = inj_ready;
   assign fwd_valid_o  = fwd;
   assign fwd_entry_o  = head;
   assign count_o      = count_q;
   assign out_valid_o  = head_local;
   assign out_data_o   = head[WIDTH-1:0];
   assign stalled_o    = (head_act == HD_STALL);
   assign drop_pulse_o = drop_q;

endmodule

// File: rtl/ring_relay_buffer.sv
// NODES-stop relay ring: wires node n to node (n+1) mod NODES and slices the flat ports per node.
module ring_relay_buffer
   import ring_relay_pkg::*;
#(
   parameter int NODES = 2,
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                rst,
   ring_relay_buffer_if.slave ring
);

   localparam int DW = dest_w(NODES);
   localparam int CW = cnt_w(DEPTH);
   localparam int EW = entry_w(NODES, WIDTH);

   logic          fwd_valid [NODES];
   logic [EW-1:0] fwd_entry [NODES];
   logic [CW-1:0] count     [NODES];

   for (genvar n = 0; n < NODES; n++) begin : g_node
      localparam int UP = (n + NODES - 1) % NODES;
      localparam int DN = (n + 1) % NODES;

      ring_node #(
         .NODES (NODES),
         .WIDTH (WIDTH),
         .DEPTH (DEPTH),
         .ID    (n)
      ) u_node (
         .clk          (clk),
         .rst          (rst),
         .inj_valid_i  (ring.inj_valid[n]),
         .inj_data_i   (ring.inj_data[n*WIDTH +: WIDTH]),
         .inj_dest_i   (ring.inj_dest[n*DW +: DW]),
         .inj_ready_o  (ring.inj_ready[n]),
         .ring_valid_i (fwd_valid[UP]),
         .ring_entry_i (fwd_entry[UP]),
         .ds_count_i   (count[DN]),
         .fwd_valid_o  (fwd_valid[n]),
         .fwd_entry_o  (fwd_entry[n]),
         .count_o      (count[n]),
         .out_valid_o  (ring.out_valid[n]),
         .out_data_o   (ring.out_data[n*WIDTH +: WIDTH]),
         .out_ready_i  (ring.out_ready[n]),
         .stalled_o    (ring.stalled[n]),
         .drop_pulse_o (ring.drop_pulse[n])
      );

      assign ring.occupancy[n*CW +: CW] = count[n];
   end

endmodule

// File: tb/tb_ring_relay_buffer.sv
// Bench for ring_relay_buffer (3 nodes, 3-bit data, depth 4): directed scenarios plus random traffic vs a queue model.
module tb_ring_relay_buffer;

   localparam int NODES = 3;
   localparam int WIDTH = 3;
   localparam int DEPTH = 4;
   localparam int DW    = 2;
   localparam int CW    = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ring_relay_buffer_if #(.NODES(NODES), .WIDTH(WIDTH), .DEPTH(DEPTH)) ring ();

   ring_relay_buffer #(.NODES(NODES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .ring (ring)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: one queue per node, each word stored as dest*16 + data.
   int               mq [NODES][$];
   logic [NODES-1:0] m_drop = '0;

   function automatic int m_dest(int n);
      return mq[n][0] / 16;
   endfunction

   function automatic bit m_local(int n);
      return (mq[n].size() > 0) && (m_dest(n) == n);
   endfunction

   function automatic bit m_fwd(int n);
      return (mq[n].size() > 0) && (m_dest(n) != n) && (mq[(n + 1) % NODES].size() < DEPTH);
   endfunction

   function automatic bit m_inj_ready(int n);
      return (mq[n].size() <= DEPTH - 2) && !m_fwd((n + NODES - 1) % NODES);
   endfunction

   function automatic bit m_stalled(int n);
      return (mq[n].size() > 0) && !m_fwd(n) && !(m_local(n) && ring.out_ready[n]);
   endfunction

   function automatic logic [NODES*CW-1:0] m_occ_vec();
      logic [NODES*CW-1:0] v = '0;
      for (int n = 0; n < NODES; n++) v[n*CW +: CW] = CW'(mq[n].size());
      return v;
   endfunction

   function automatic int occ(int n);
      return int'(ring.occupancy[n*CW +: CW]);
   endfunction

   function automatic int odata(int n);
      return int'(ring.out_data[n*WIDTH +: WIDTH]);
   endfunction

   task automatic drive(int n, bit v, int dest, int data);
      ring.inj_valid[n]               = v;
      ring.inj_dest[n*DW +: DW]       = DW'(dest);
      ring.inj_data[n*WIDTH +: WIDTH] = WIDTH'(data);
   endtask

   // Advance one clock and apply the same edge to the model; returns at edge + 1.
   task automatic tick();
      bit f [NODES];
      bit p [NODES];
      bit a [NODES];
      int e [NODES];
      int d [NODES];
      int w [NODES];
      bit r;
      r = rst;
      for (int n = 0; n < NODES; n++) begin
         f[n] = m_fwd(n);
         p[n] = f[n] || (m_local(n) && ring.out_ready[n]);
         a[n] = ring.inj_valid[n] && m_inj_ready(n);
         e[n] = (mq[n].size() > 0) ? mq[n][0] : 0;
         d[n] = int'(ring.inj_dest[n*DW +: DW]);
         w[n] = int'(ring.inj_data[n*WIDTH +: WIDTH]);
      end
      @(posedge clk);
      if (!r) begin
         for (int n = 0; n < NODES; n++) mq[n].delete();
         m_drop = '0;
      end else begin
         for (int n = 0; n < NODES; n++)
            if (p[n]) void'(mq[n].pop_front());
         for (int n = 0; n < NODES; n++) begin
            m_drop[n] = a[n] && (d[n] >= NODES);
            if (f[(n + NODES - 1) % NODES]) mq[n].push_back(e[(n + NODES - 1) % NODES]);
            else if (a[n] && (d[n] < NODES)) mq[n].push_back(d[n] * 16 + w[n]);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst            = 1'b0;
      ring.inj_valid = '0;
      ring.inj_data  = '0;
      ring.inj_dest  = '0;
      ring.out_ready = '0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      total++; if (ring.occupancy !== '0) begin bad++; $display("FAIL reset_occupancy got=%h want=0", ring.occupancy); end
      total++; if (ring.out_valid !== 3'b000) begin bad++; $display("FAIL reset_out_valid got=%b want=000", ring.out_valid); end
      total++; if (ring.inj_ready !== 3'b111) begin bad++; $display("FAIL reset_inj_ready got=%b want=111", ring.inj_ready); end
      total++; if (ring.stalled !== 3'b000) begin bad++; $display("FAIL reset_stalled got=%b want=000", ring.stalled); end
      total++; if (ring.drop_pulse !== 3'b000) begin bad++; $display("FAIL reset_drop got=%b want=000", ring.drop_pulse); end
   endtask

   task automatic test_local();
      drive(1, 1'b1, 1, 5);
      #1;
      total++; if (ring.inj_ready[1] !== 1'b1) begin bad++; $display("FAIL local_inj_ready got=%b want=1", ring.inj_ready[1]); end
      tick();
      drive(1, 1'b0, 0, 0);
      total++; if (ring.out_valid !== 3'b010) begin bad++; $display("FAIL local_out_valid got=%b want=010", ring.out_valid); end
      total++; if (odata(1) !== 5) begin bad++; $display("FAIL local_out_data got=%0d want=5", odata(1)); end
      total++; if (occ(1) !== 1) begin bad++; $display("FAIL local_occ_full got=%0d want=1", occ(1)); end
      ring.out_ready[1] = 1'b1;
      tick();
      ring.out_ready[1] = 1'b0;
      total++; if (occ(1) !== 0) begin bad++; $display("FAIL local_occ_empty got=%0d want=0", occ(1)); end
      total++; if (ring.out_valid !== 3'b000) begin bad++; $display("FAIL local_out_gone got=%b want=000", ring.out_valid); end
   endtask

   task automatic test_multihop();
      logic [NODES*CW-1:0] exp_occ;
      drive(0, 1'b1, 2, 3);
      tick();
      drive(0, 1'b0, 0, 0);
      exp_occ = {3'd0, 3'd0, 3'd1};
      total++; if (ring.occupancy !== exp_occ) begin bad++; $display("FAIL hop_t1_occ got=%h want=%h", ring.occupancy, exp_occ); end
      total++; if (ring.out_valid !== 3'b000) begin bad++; $display("FAIL hop_t1_valid got=%b want=000", ring.out_valid); end
      tick();
      exp_occ = {3'd0, 3'd1, 3'd0};
      total++; if (ring.occupancy !== exp_occ) begin bad++; $display("FAIL hop_t2_occ got=%h want=%h", ring.occupancy, exp_occ); end
      total++; if (ring.out_valid !== 3'b000) begin bad++; $display("FAIL hop_t2_valid got=%b want=000", ring.out_valid); end
      tick();
      exp_occ = {3'd1, 3'd0, 3'd0};
      total++; if (ring.occupancy !== exp_occ) begin bad++; $display("FAIL hop_t3_occ got=%h want=%h", ring.occupancy, exp_occ); end
      total++; if (ring.out_valid !== 3'b100) begin bad++; $display("FAIL hop_t3_valid got=%b want=100", ring.out_valid); end
      total++; if (odata(2) !== 3) begin bad++; $display("FAIL hop_t3_data got=%0d want=3", odata(2)); end
      ring.out_ready[2] = 1'b1;
      tick();
      ring.out_ready[2] = 1'b0;
      total++; if (ring.occupancy !== '0) begin bad++; $display("FAIL hop_drained got=%h want=0", ring.occupancy); end
   endtask

   task automatic test_backpressure();
      int sent [$];
      int got  [$];
      bit saw_full;
      logic [NODES*CW-1:0] exp_occ;
      saw_full       = 1'b0;
      ring.out_ready = '0;
      for (int c = 0; c < 20; c++) begin
         int w;
         w = $urandom_range(0, 7);
         drive(0, 1'b1, 2, w);
         #1;
         total++; if (ring.inj_ready[0] !== m_inj_ready(0)) begin bad++; $display("FAIL bp_inj_ready cyc=%0d got=%b want=%b", c, ring.inj_ready[0], m_inj_ready(0)); end
         if (occ(0) >= 3) begin
            saw_full = 1'b1;
            total++; if (ring.inj_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_bubble cyc=%0d got=%b want=0", c, ring.inj_ready[0]); end
         end
         if (m_inj_ready(0)) sent.push_back(w);
         tick();
      end
      exp_occ = {3'd4, 3'd4, 3'd3};
      total++; if (ring.occupancy !== exp_occ) begin bad++; $display("FAIL bp_fill got=%h want=%h", ring.occupancy, exp_occ); end
      total++; if (ring.stalled !== 3'b111) begin bad++; $display("FAIL bp_stalled got=%b want=111", ring.stalled); end
      total++; if (saw_full !== 1'b1) begin bad++; $display("FAIL bp_node0_full got=%b want=1", saw_full); end
      drive(0, 1'b0, 0, 0);
      ring.out_ready[2] = 1'b1;
      #1;
      for (int c = 0; c < 40 && got.size() < sent.size(); c++) begin
         if (ring.out_valid[2]) got.push_back(odata(2));
         tick();
      end
      ring.out_ready[2] = 1'b0;
      total++; if (got.size() != sent.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got.size(), sent.size()); end
      for (int i = 0; i < got.size() && i < sent.size(); i++) begin
         total++; if (got[i] !== sent[i]) begin bad++; $display("FAIL bp_order idx=%0d got=%0d want=%0d", i, got[i], sent[i]); end
      end
      total++; if (ring.occupancy !== '0) begin bad++; $display("FAIL bp_drained got=%h want=0", ring.occupancy); end
   endtask

   task automatic test_collision();
      logic [NODES*CW-1:0] exp_occ;
      bit seen;
      ring.out_ready = '1;
      drive(0, 1'b1, 2, 4);
      tick();
      drive(0, 1'b0, 0, 0);
      drive(1, 1'b1, 1, 6);
      #1;
      total++; if (ring.inj_ready[1] !== 1'b0) begin bad++; $display("FAIL coll_blocked got=%b want=0", ring.inj_ready[1]); end
      tick();
      exp_occ = {3'd0, 3'd1, 3'd0};
      total++; if (ring.occupancy !== exp_occ) begin bad++; $display("FAIL coll_occ got=%h want=%h", ring.occupancy, exp_occ); end
      total++; if (ring.inj_ready[1] !== 1'b1) begin bad++; $display("FAIL coll_retry_ready got=%b want=1", ring.inj_ready[1]); end
      tick();
      drive(1, 1'b0, 0, 0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (ring.out_valid[1] && odata(1) == 6) seen = 1'b1;
         tick();
      end
      ring.out_ready = '0;
      total++; if (seen !== 1'b1) begin bad++; $display("FAIL coll_delivered got=%b want=1", seen); end
      total++; if (ring.occupancy !== '0) begin bad++; $display("FAIL coll_drained got=%h want=0", ring.occupancy); end
   endtask

   task automatic test_bad_dest();
      logic [NODES*CW-1:0] exp_occ;
      exp_occ = m_occ_vec();
      drive(2, 1'b1, 3, 1);
      #1;
      total++; if (ring.inj_ready[2] !== 1'b1) begin bad++; $display("FAIL bad_ready got=%b want=1", ring.inj_ready[2]); end
      tick();
      drive(2, 1'b0, 0, 0);
      total++; if (ring.drop_pulse !== 3'b100) begin bad++; $display("FAIL bad_pulse got=%b want=100", ring.drop_pulse); end
      total++; if (ring.occupancy !== exp_occ) begin bad++; $display("FAIL bad_occ got=%h want=%h", ring.occupancy, exp_occ); end
      tick();
      total++; if (ring.drop_pulse !== 3'b000) begin bad++; $display("FAIL bad_pulse_end got=%b want=000", ring.drop_pulse); end
   endtask

   task automatic test_reset_midflight();
      int sum;
      ring.out_ready = '0;
      for (int c = 0; c < 5; c++) begin
         drive(0, 1'b1, 2, c);
         tick();
      end
      drive(0, 1'b0, 0, 0);
      sum = occ(0) + occ(1) + occ(2);
      total++; if (sum !== 5) begin bad++; $display("FAIL mid_in_flight got=%0d want=5", sum); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      total++; if (ring.occupancy !== '0) begin bad++; $display("FAIL mid_occ got=%h want=0", ring.occupancy); end
      total++; if (ring.out_valid !== 3'b000) begin bad++; $display("FAIL mid_out_valid got=%b want=000", ring.out_valid); end
      total++; if (ring.inj_ready !== 3'b111) begin bad++; $display("FAIL mid_inj_ready got=%b want=111", ring.inj_ready); end
   endtask

   task automatic test_random();
      logic [NODES-1:0] e_rdy, e_ov, e_st;
      for (int c = 0; c < 600; c++) begin
         for (int n = 0; n < NODES; n++)
            drive(n, $urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom_range(0, 7));
         ring.out_ready = 3'($urandom);
         rst = ($urandom_range(0, 99) != 0);
         #1;
         for (int n = 0; n < NODES; n++) begin
            e_rdy[n] = m_inj_ready(n);
            e_ov[n]  = m_local(n);
            e_st[n]  = m_stalled(n);
         end
         total++; if (ring.inj_ready !== e_rdy) begin bad++; $display("FAIL rnd_inj_ready cyc=%0d got=%b want=%b", c, ring.inj_ready, e_rdy); end
         total++; if (ring.out_valid !== e_ov) begin bad++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", c, ring.out_valid, e_ov); end
         total++; if (ring.stalled !== e_st) begin bad++; $display("FAIL rnd_stalled cyc=%0d got=%b want=%b", c, ring.stalled, e_st); end
         total++; if (ring.occupancy !== m_occ_vec()) begin bad++; $display("FAIL rnd_occ cyc=%0d got=%h want=%h", c, ring.occupancy, m_occ_vec()); end
         total++; if (ring.drop_pulse !== m_drop) begin bad++; $display("FAIL rnd_drop cyc=%0d got=%b want=%b", c, ring.drop_pulse, m_drop); end
         for (int n = 0; n < NODES; n++) begin
            if (e_ov[n]) begin
               total++; if (odata(n) !== mq[n][0] % 16) begin bad++; $display("FAIL rnd_out_data cyc=%0d node=%0d got=%0d want=%0d", c, n, odata(n), mq[n][0] % 16); end
            end
         end
         tick();
      end
      rst = 1'b1;
   endtask

   task automatic test_drain();
      ring.inj_valid = '0;
      ring.out_ready = '1;
      #1;
      for (int c = 0; c < 60 && ring.occupancy != '0; c++) tick();
      total++; if (ring.occupancy !== '0) begin bad++; $display("FAIL drain_empty got=%h want=0", ring.occupancy); end
      ring.out_ready = '0;
   endtask

   initial begin
      test_reset();
      test_local();
      test_multihop();
      test_backpressure();
      test_collision();
      test_bad_dest();
      test_reset_midflight();
      test_random();
      test_drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
